// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: LED pattern engine with four run-time patterns
// (flash, rotate-left, rotate-right, ping-pong) paced by a programmable prescaler.
// A pattern step happens every i_period+1 enabled cycles. o_tick marks the cycle
// in which the new pattern is first visible on o_led.
module led_pattern_ctrl #(
  parameter int NB_LED   = 4,
  parameter int NB_COUNT = 32
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic [NB_COUNT-1:0] i_period,
  output logic [NB_LED-1:0]   o_led,
  output logic                o_tick
);

  typedef enum logic [1:0] {
    MODE_FLASH = 2'b00,
    MODE_ROTL  = 2'b01,
    MODE_ROTR  = 2'b10,
    MODE_PING  = 2'b11
  } mode_t;

  localparam logic [NB_LED-1:0] SEED_LSB = NB_LED'(1);
  localparam logic [NB_LED-1:0] SEED_MSB = {1'b1, {(NB_LED-1){1'b0}}};

  logic [NB_COUNT-1:0] count_q, count_d;
  mode_t               mode_q, mode_d;
  logic                dir_q, dir_d;    // ping-pong: 0 = toward MSB, 1 = toward LSB
  logic [NB_LED-1:0]   led_q, led_d;
  logic                tick_q, tick_d;

  logic [NB_LED-1:0]   ping_next;
  logic                step_due;

  // A step is due once the prescaler has reached the terminal count. Using >=
  // means lowering i_period below the running count steps at once instead of
  // wrapping through the full counter range.
  assign step_due = (count_q >= i_period);

  // Ping-pong next pattern: move the single hot bit one place in the current direction.
  always_comb begin
    ping_next = led_q;
    if (!dir_q) begin
      ping_next = led_q << 1;
    end else begin
      ping_next = led_q >> 1;
    end
  end

  // Next-state: reset is handled in the register, then mode load, step, count, idle.
  always_comb begin
    count_d = count_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    led_d   = led_q;
    tick_d  = 1'b0;

    if (i_mode != mode_q) begin
      // Mode change: restart the pattern from its seed regardless of i_enable.
      mode_d  = mode_t'(i_mode);
      count_d = '0;
      dir_d   = 1'b0;
      case (mode_t'(i_mode))
        MODE_FLASH: led_d = '0;
        MODE_ROTL:  led_d = SEED_LSB;
        MODE_ROTR:  led_d = SEED_MSB;
        MODE_PING:  led_d = SEED_LSB;
        default:    led_d = '0;
      endcase
    end else if (i_enable) begin
      if (step_due) begin
        count_d = '0;
        tick_d  = 1'b1;
        case (mode_q)
          MODE_FLASH: led_d = ~led_q;
          MODE_ROTL:  led_d = {led_q[NB_LED-2:0], led_q[NB_LED-1]};
          MODE_ROTR:  led_d = {led_q[0], led_q[NB_LED-1:1]};
          MODE_PING: begin
            led_d = ping_next;
            // Turn around as soon as an endpoint is lit so it shows only once per bounce.
            if (ping_next[NB_LED-1]) begin
              dir_d = 1'b1;
            end else if (ping_next[0]) begin
              dir_d = 1'b0;
            end
          end
          default:    led_d = led_q;
        endcase
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      count_q <= '0;
      mode_q  <= MODE_FLASH;
      dir_q   <= 1'b0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  end

  assign o_led  = led_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed scenarios plus randomized stimulus, with every
// output cycle compared against a step-index model of the LED patterns.
module tb_led_pattern_ctrl;

  localparam int NB_LED   = 4;
  localparam int NB_COUNT = 32;

  logic                clock;
  logic                i_reset;
  logic                i_enable;
  logic [1:0]          i_mode;
  logic [NB_COUNT-1:0] i_period;
  logic [NB_LED-1:0]   o_led;
  logic                o_tick;

  int checks = 0;
  int errors = 0;

  led_pattern_ctrl #(
    .NB_LED  (NB_LED),
    .NB_COUNT(NB_COUNT)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_mode  (i_mode),
    .i_period(i_period),
    .o_led   (o_led),
    .o_tick  (o_tick)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The pattern is a pure function of the mode and the number of steps taken
  // since the last load/reset; the prescaler is "enabled cycles since last step".
  bit            m_valid = 0;
  logic [1:0]    m_mode;
  longint        m_cnt;
  int            m_k;
  logic          m_tick;

  function automatic logic [NB_LED-1:0] model_led(input logic [1:0] md, input int k);
    logic [NB_LED-1:0] r;
    int m;
    int pos;
    r = '0;
    case (md)
      2'b00: r = (k % 2 == 1) ? '1 : '0;
      2'b01: r[k % NB_LED] = 1'b1;
      2'b10: r[NB_LED-1 - (k % NB_LED)] = 1'b1;
      default: begin
        m   = k % (2 * (NB_LED - 1));
        pos = (m < NB_LED) ? m : 2 * (NB_LED - 1) - m;
        r[pos] = 1'b1;
      end
    endcase
    return r;
  endfunction

  always @(posedge clock) begin
    if (i_reset) begin
      m_valid = 1;
      m_mode  = 2'b00;
      m_cnt   = 0;
      m_k     = 0;
      m_tick  = 0;
    end else if (m_valid) begin
      if (i_mode != m_mode) begin
        m_mode = i_mode;
        m_cnt  = 0;
        m_k    = 0;
        m_tick = 0;
      end else if (i_enable) begin
        if (m_cnt >= longint'(i_period)) begin
          m_cnt  = 0;
          m_k    = (m_k + 1) % (4 * NB_LED * (NB_LED - 1));
          m_tick = 1;
        end else begin
          m_cnt  = m_cnt + 1;
          m_tick = 0;
        end
      end else begin
        m_tick = 0;
      end
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(posedge clock) begin
    #1;
    if (m_valid) begin
      check("model_led", 32'(o_led), 32'(model_led(m_mode, m_k)));
      check("model_tick", 32'(o_tick), 32'(m_tick));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic en, input logic [1:0] md, input logic [NB_COUNT-1:0] per);
    i_enable = en;
    i_mode   = md;
    i_period = per;
  endtask

  // ---------------- stimulus ----------------
  logic [NB_LED-1:0] rotl_seq[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NB_LED-1:0] ping_seq[7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

  initial begin
    i_reset = 1'b1;
    drive(1'b0, 2'b00, '0);
    cycles(2);
    i_reset = 1'b0;
    check("reset_led", 32'(o_led), 32'h0);
    check("reset_tick", 32'(o_tick), 32'h0);

    // Flash, period 3: toggles every 4 edges.
    drive(1'b1, 2'b00, 32'd3);
    cycles(3);
    check("flash_pre_led", 32'(o_led), 32'h0);
    check("flash_pre_tick", 32'(o_tick), 32'h0);
    cycles(1);
    check("flash_on_led", 32'(o_led), 32'hF);
    check("flash_on_tick", 32'(o_tick), 32'h1);
    cycles(1);
    check("flash_tick_drop", 32'(o_tick), 32'h0);
    cycles(3);
    check("flash_off_led", 32'(o_led), 32'h0);
    check("flash_off_tick", 32'(o_tick), 32'h1);

    // Rotate-left, period 0: steps every cycle with wrap.
    drive(1'b1, 2'b01, 32'd0);
    cycles(1);
    check("rotl_seed", 32'(o_led), 32'h1);
    check("rotl_seed_tick", 32'(o_tick), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      check("rotl_seq", 32'(o_led), 32'(rotl_seq[i]));
      check("rotl_tick", 32'(o_tick), 32'h1);
    end

    // Ping-pong, period 0: endpoints lit once per bounce.
    drive(1'b1, 2'b11, 32'd0);
    cycles(1);
    check("ping_seed", 32'(o_led), 32'h1);
    for (int i = 0; i < 7; i++) begin
      cycles(1);
      check("ping_seq", 32'(o_led), 32'(ping_seq[i]));
    end

    // Rotate-right, period 9, enable dropped mid-count.
    drive(1'b1, 2'b10, 32'd9);
    cycles(1);
    check("rotr_seed", 32'(o_led), 32'h8);
    cycles(5);
    i_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check("hold_led", 32'(o_led), 32'h8);
      check("hold_tick", 32'(o_tick), 32'h0);
    end
    i_enable = 1'b1;
    cycles(4);
    check("resume_pre_led", 32'(o_led), 32'h8);
    cycles(1);
    check("resume_step_led", 32'(o_led), 32'h4);
    check("resume_step_tick", 32'(o_tick), 32'h1);

    // Period lowered below the running count: immediate step.
    drive(1'b1, 2'b01, 32'd100);
    cycles(1);
    check("lower_seed", 32'(o_led), 32'h1);
    cycles(50);
    check("lower_wait_led", 32'(o_led), 32'h1);
    i_period = 32'd10;
    cycles(1);
    check("lower_step_led", 32'(o_led), 32'h2);
    check("lower_step_tick", 32'(o_tick), 32'h1);
    cycles(10);
    check("lower_gap_led", 32'(o_led), 32'h2);
    cycles(1);
    check("lower_next_led", 32'(o_led), 32'h4);
    check("lower_next_tick", 32'(o_tick), 32'h1);
    cycles(3);
    i_mode = 2'b00;
    cycles(1);
    check("modechg_led", 32'(o_led), 32'h0);
    check("modechg_tick", 32'(o_tick), 32'h0);

    // Reset during ping-pong with dir toward LSB, then reload.
    drive(1'b1, 2'b11, 32'd0);
    cycles(1);
    check("ping2_seed", 32'(o_led), 32'h1);
    cycles(4);
    check("ping2_back", 32'(o_led), 32'h4);
    i_reset = 1'b1;
    cycles(1);
    check("midreset_led", 32'(o_led), 32'h0);
    check("midreset_tick", 32'(o_tick), 32'h0);
    i_reset = 1'b0;
    cycles(1);
    check("reload_seed", 32'(o_led), 32'h1);
    cycles(1);
    check("reload_msb_dir", 32'(o_led), 32'h2);
    check("reload_tick", 32'(o_tick), 32'h1);

    // Randomized stimulus checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      i_reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) i_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) i_period = 32'($urandom_range(0, 40));
        else                          i_period = 32'($urandom_range(0, 6));
      end
      i_enable = ($urandom_range(0, 9) < 8);
      cycles(1);
    end
    i_reset = 1'b0;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
